// File: rtl/ldu_pkg.sv
// Shared load-type encodings, FSM state encoding and access-size constants
// for the load alignment unit.
package ldu_pkg;

    typedef enum logic [2:0] {
        LD_LW   = 3'b000,
        LD_LB   = 3'b001,
        LD_LH   = 3'b010,
        LD_LBU  = 3'b011,
        LD_LHU  = 3'b100,
        LD_LWRR = 3'b101
    } ld_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LO,
        ST_RD_HI,
        ST_WAIT,
        ST_RESP
    } ldu_state_e;

    localparam logic [2:0] SIZE_BYTE = 3'd1;
    localparam logic [2:0] SIZE_HALF = 3'd2;
    localparam logic [2:0] SIZE_WORD = 3'd4;

    // Reserved encodings 110/111 behave as a plain word load.
    function automatic ld_type_e decode_type(input logic [2:0] raw);
        ld_type_e t;
        case (raw)
            3'b001:  t = LD_LB;
            3'b010:  t = LD_LH;
            3'b011:  t = LD_LBU;
            3'b100:  t = LD_LHU;
            3'b101:  t = LD_LWRR;
            default: t = LD_LW;
        endcase
        return t;
    endfunction

    function automatic logic [2:0] access_size(input ld_type_e t);
        logic [2:0] s;
        case (t)
            LD_LB, LD_LBU: s = SIZE_BYTE;
            LD_LH, LD_LHU: s = SIZE_HALF;
            default:       s = SIZE_WORD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ldu_extract.sv
// Combinational lane select, two-beat merge, sign/zero extension and
// LWRR lane rotation for the load alignment unit.
module ldu_extract
    import ldu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] lo_beat,
    input  logic [DATA_W-1:0] hi_beat,
    input  logic [OFF_W-1:0]  off,
    input  ld_type_e          ld_type,
    output logic [31:0]       data
);

    logic [OFF_W+2:0] byte_sh;
    logic [OFF_W+2:0] lane_sh;
    logic [OFF_W-1:0] lane_off;
    logic [31:0]      span_word;
    logic [31:0]      lane_word;
    logic [31:0]      rot_word;

    // hi_beat is zero for single-beat loads, so one shifter covers both cases.
    assign byte_sh   = {off, 3'b000};
    assign span_word = 32'({hi_beat, lo_beat} >> byte_sh);

    assign lane_off  = off & ~OFF_W'(3);
    assign lane_sh   = {lane_off, 3'b000};
    assign lane_word = 32'(lo_beat >> lane_sh);
    assign rot_word  = 32'({lane_word, lane_word} >> {off[1:0], 3'b000});

    always_comb begin
        data = '0;
        case (ld_type)
            LD_LB:   data = {{24{span_word[7]}}, span_word[7:0]};
            LD_LBU:  data = {24'h0, span_word[7:0]};
            LD_LH:   data = {{16{span_word[15]}}, span_word[15:0]};
            LD_LHU:  data = {16'h0, span_word[15:0]};
            LD_LWRR: data = rot_word;
            default: data = span_word;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: issues aligned memory reads for byte/half/word loads and
// returns the extended result. LDU_UNALIGNED_SPLIT_EN enables two-beat spanning loads.
//
// state    | meaning
// IDLE     | ready for a request
// RD_LO    | read aligned beat containing the first byte
// RD_HI    | read next beat, capture first beat (spanning only)
// WAIT     | capture final beat, build response data
// RESP     | hold response until rsp_ready
module load_align_unit
    import ldu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [2:0]        req_type,
    input  logic [4:0]        req_rd,
    output logic              mem_rd_en,
    output logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_exc
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int END_W = OFF_W + 2;

    ldu_state_e        state;
    ldu_state_e        state_nxt;
    logic [31:0]       addr_q;
    ld_type_e          type_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] lo_beat_q;
    logic [31:0]       rsp_data_q;
    logic              rsp_exc_q;

    logic              accept;
    logic              req_exc;
    logic              cur_span;
    logic [31:0]       aligned_addr;
    logic [DATA_W-1:0] ext_lo;
    logic [DATA_W-1:0] ext_hi;
    logic [31:0]       ext_data;

    function automatic logic is_spanning(input logic [31:0] a, input ld_type_e t);
        logic [END_W-1:0] end_off;
        end_off = END_W'(a[OFF_W-1:0]) + END_W'(access_size(t));
        return (t != LD_LWRR) && (end_off > END_W'(BYTES));
    endfunction

    assign accept    = req_valid && req_ready;
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rd_q;
    assign rsp_exc   = rsp_exc_q;

`ifdef LDU_UNALIGNED_SPLIT_EN
    assign req_exc = 1'b0;
`else
    assign req_exc = is_spanning(req_addr, decode_type(req_type));
`endif

    assign cur_span     = is_spanning(addr_q, type_q);
    assign aligned_addr = addr_q & ~32'(BYTES - 1);

    // In WAIT the live bus carries the high beat of a spanning load, else the only beat.
    assign ext_lo = cur_span ? lo_beat_q : mem_rdata;
    assign ext_hi = cur_span ? mem_rdata : '0;

    ldu_extract #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_extract (
        .lo_beat (ext_lo),
        .hi_beat (ext_hi),
        .off     (addr_q[OFF_W-1:0]),
        .ld_type (type_q),
        .data    (ext_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = req_exc ? ST_RESP : ST_RD_LO;
                end
            end
            ST_RD_LO: begin
                mem_rd_en = 1'b1;
                mem_addr  = aligned_addr;
`ifdef LDU_UNALIGNED_SPLIT_EN
                state_nxt = cur_span ? ST_RD_HI : ST_WAIT;
`else
                state_nxt = ST_WAIT;
`endif
            end
            ST_RD_HI: begin
                mem_rd_en = 1'b1;
                mem_addr  = aligned_addr + 32'(BYTES);
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            type_q     <= LD_LW;
            rd_q       <= '0;
            lo_beat_q  <= '0;
            rsp_data_q <= '0;
            rsp_exc_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                type_q     <= decode_type(req_type);
                rd_q       <= req_rd;
                rsp_data_q <= '0;
                rsp_exc_q  <= req_exc;
            end
            if (state == ST_RD_HI) begin
                lo_beat_q <= mem_rdata;
            end
            if (state == ST_WAIT) begin
                rsp_data_q <= ext_data;
                rsp_exc_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: 32-bit and 64-bit instances share
// a byte memory; a reference model fills a scoreboard checked at each response.
module tb_load_align_unit;

`ifdef LDU_UNALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, rsp_ready, sel64;
    logic [31:0] req_addr;
    logic [2:0]  req_type;
    logic [4:0]  req_rd;

    logic        req_valid32, req_ready32, mem_rd_en32, rsp_valid32, rsp_exc32;
    logic [31:0] mem_addr32, rsp_data32, mem_rdata32;
    logic [4:0]  rsp_rd32;
    logic        req_valid64, req_ready64, mem_rd_en64, rsp_valid64, rsp_exc64;
    logic [31:0] mem_addr64, rsp_data64;
    logic [63:0] mem_rdata64;
    logic [4:0]  rsp_rd64;

    logic        req_ready_m, mem_rd_en_m, rsp_valid_m, rsp_exc_m;
    logic [31:0] rsp_data_m;
    logic [4:0]  rsp_rd_m;

    int n_checks = 0;
    int n_fail   = 0;
    int leak_cnt = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        exc;
        int          lat;
        int          nrd;
        logic [31:0] a0;
        logic [31:0] a1;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rd_log[$];
    logic [7:0]  mem[bit [31:0]];

    always #5 clk = ~clk;

    assign req_valid32 = req_valid && !sel64;
    assign req_valid64 = req_valid && sel64;
    assign req_ready_m = sel64 ? req_ready64 : req_ready32;
    assign mem_rd_en_m = sel64 ? mem_rd_en64 : mem_rd_en32;
    assign rsp_valid_m = sel64 ? rsp_valid64 : rsp_valid32;
    assign rsp_exc_m   = sel64 ? rsp_exc64   : rsp_exc32;
    assign rsp_data_m  = sel64 ? rsp_data64  : rsp_data32;
    assign rsp_rd_m    = sel64 ? rsp_rd64    : rsp_rd32;

    load_align_unit #(.DATA_W(32)) u_dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid32), .req_ready(req_ready32),
        .req_addr(req_addr), .req_type(req_type), .req_rd(req_rd),
        .mem_rd_en(mem_rd_en32), .mem_addr(mem_addr32), .mem_rdata(mem_rdata32),
        .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data32), .rsp_rd(rsp_rd32), .rsp_exc(rsp_exc32)
    );

    load_align_unit #(.DATA_W(64)) u_dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid64), .req_ready(req_ready64),
        .req_addr(req_addr), .req_type(req_type), .req_rd(req_rd),
        .mem_rd_en(mem_rd_en64), .mem_addr(mem_addr64), .mem_rdata(mem_rdata64),
        .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data64), .rsp_rd(rsp_rd64), .rsp_exc(rsp_exc64)
    );

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [63:0] mword(input logic [31:0] a, input int nb);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < nb; i++) w[8*i +: 8] = mbyte(a + 32'(i));
        return w;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) mem[a + 32'(i)] = v[8*i +: 8];
    endtask

    // Memory: data valid the cycle after a read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (mem_rd_en32) begin
            mem_rdata32 <= 32'(mword(mem_addr32, 4));
            rd_log.push_back(mem_addr32);
        end else begin
            mem_rdata32 <= 32'hDEAD_BEEF;
        end
        if (mem_rd_en64) begin
            mem_rdata64 <= mword(mem_addr64, 8);
            rd_log.push_back(mem_addr64);
        end else begin
            mem_rdata64 <= 64'hDEAD_BEEF_CAFE_F00D;
        end
    end

    always @(negedge clk) begin
        if ((!mem_rd_en32 && mem_addr32 != 0) || (!mem_rd_en64 && mem_addr64 != 0)) leak_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_load(input logic [31:0] addr, input logic [2:0] typ,
                                      input logic [4:0] rd, input int nbytes);
        exp_t        e;
        int          size, off;
        bit          span, lwrr;
        logic [31:0] raw, base;
        lwrr = (typ == 3'd5);
        size = (typ == 3'd1 || typ == 3'd3) ? 1 : (typ == 3'd2 || typ == 3'd4) ? 2 : 4;
        off  = int'(addr & 32'(nbytes - 1));
        span = !lwrr && (off + size > nbytes);
        e.rd = rd;
        e.a0 = addr & ~32'(nbytes - 1);
        e.a1 = e.a0 + 32'(nbytes);
        if (span && !SPLIT) begin
            e.exc = 1'b1; e.data = '0; e.lat = 1; e.nrd = 0;
        end else begin
            e.exc = 1'b0;
            e.lat = span ? 4 : 3;
            e.nrd = span ? 2 : 1;
            if (lwrr) begin
                base = addr & ~32'd3;
                for (int i = 0; i < 4; i++)
                    e.data[8*i +: 8] = mbyte(base + 32'((int'(addr[1:0]) + i) % 4));
            end else begin
                raw = '0;
                for (int i = 0; i < size; i++) raw[8*i +: 8] = mbyte(addr + 32'(i));
                case (typ)
                    3'd1:    e.data = {{24{raw[7]}}, raw[7:0]};
                    3'd2:    e.data = {{16{raw[15]}}, raw[15:0]};
                    default: e.data = raw;
                endcase
            end
        end
        return e;
    endfunction

    task automatic do_load(input logic [31:0] addr, input logic [2:0] typ, input logic [4:0] rd,
                           input bit w64, input int hold);
        exp_t e;
        int   n, lat;
        @(negedge clk);
        sel64 = w64; req_addr = addr; req_type = typ; req_rd = rd;
        req_valid = 1'b1; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready_m && n < 20) begin @(negedge clk); n++; end
        check("req_ready_wait", 64'(n < 20), 1);
        rd_log.delete();
        sb.push_back(ref_load(addr, typ, rd, w64 ? 8 : 4));
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr = $urandom; req_type = 3'($urandom); req_rd = 5'($urandom);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid_m) break;
        end
        e = sb.pop_front();
        check("latency", 64'(lat), 64'(e.lat));
        check("rsp_data", rsp_data_m, e.data);
        check("rsp_rd", rsp_rd_m, e.rd);
        check("rsp_exc", rsp_exc_m, e.exc);
        check("mem_reads", 64'(rd_log.size()), 64'(e.nrd));
        if (e.nrd > 0 && rd_log.size() > 0) check("mem_addr_lo", rd_log[0], e.a0);
        if (e.nrd > 1 && rd_log.size() > 1) check("mem_addr_hi", rd_log[1], e.a1);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", rsp_valid_m, 1);
            check("hold_data", rsp_data_m, e.data);
            check("hold_rd", rsp_rd_m, e.rd);
            check("hold_ready", req_ready_m, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("release_valid", rsp_valid_m, 0);
        check("release_ready", req_ready_m, 1);
    endtask

    task automatic reset_mid_flight();
        int viol;
        @(negedge clk);
        sel64 = 1'b0; req_addr = SPLIT ? 32'h1001 : 32'h1000; req_type = 3'd0; req_rd = 5'd9;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
`ifdef LDU_UNALIGNED_SPLIT_EN
        @(negedge clk);
        check("pre_reset_hi_addr", mem_addr32, 32'h1004);
`endif
        check("pre_reset_rden", mem_rd_en32, 1);
        reset = 1'b1;
        #1;
        check("rst_rsp_valid", rsp_valid32, 0);
        check("rst_mem_rd_en", mem_rd_en32, 0);
        check("rst_mem_addr", mem_addr32, 0);
        check("rst_rsp_data", rsp_data32, 0);
        check("rst_rsp_rd", rsp_rd32, 0);
        check("rst_rsp_exc", rsp_exc32, 0);
        @(negedge clk);
        reset = 1'b0;
        viol = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid32) viol++;
        end
        check("no_rsp_after_reset", 64'(viol), 0);
        check("ready_after_reset", req_ready32, 1);
        set_word(32'h1000, 32'h80FF_1234);
        do_load(32'h1003, 3'd1, 5'd4, 1'b0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; sel64 = 1'b0;
        req_addr = '0; req_type = '0; req_rd = '0;
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", rsp_valid32, 0);
        check("reset_mem_rd_en", mem_rd_en32, 0);
        check("reset_mem_addr", mem_addr32, 0);
        check("reset_rsp_data", rsp_data32, 0);
        check("reset_rsp_rd", rsp_rd32, 0);
        check("reset_rsp_exc", rsp_exc32, 0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready32", req_ready32, 1);
        check("reset_ready64", req_ready64, 1);

        set_word(32'h1000, 32'h80FF_1234);
        do_load(32'h1003, 3'd1, 5'd5, 1'b0, 0);
        set_word(32'h3000, 32'hAABB_CCDD);
        do_load(32'h3002, 3'd5, 5'd7, 1'b0, 0);
        check("lwrr_value", rsp_data32, 32'hCCDD_AABB);
        set_word(32'h1000, 32'h4433_2211);
        set_word(32'h1004, 32'h8877_6655);
        do_load(32'h1001, 3'd0, 5'd3, 1'b0, 5);
        do_load(32'h1006, 3'd2, 5'd10, 1'b0, 0);
        do_load(32'h1006, 3'd4, 5'd11, 1'b0, 1);
        do_load(32'h1007, 3'd3, 5'd12, 1'b0, 0);
        do_load(32'h1004, 3'd6, 5'd13, 1'b0, 0);
        do_load(32'h1000, 3'd7, 5'd14, 1'b0, 0);
        do_load(32'h1003, 3'd2, 5'd15, 1'b0, 0);
        do_load(32'h1005, 3'd5, 5'd16, 1'b0, 0);
        do_load(32'hFFFF_FFFE, 3'd0, 5'd17, 1'b0, 0);

        for (int i = 0; i < 8; i++) mem[32'h2000 + 32'(i)] = 8'h00;
        mem[32'h2006] = 8'hEF;
        mem[32'h2007] = 8'hBE;
        do_load(32'h2006, 3'd4, 5'd1, 1'b1, 0);
        do_load(32'h2004, 3'd0, 5'd2, 1'b1, 0);
        do_load(32'h2006, 3'd0, 5'd3, 1'b1, 2);
        do_load(32'h2007, 3'd5, 5'd4, 1'b1, 0);
        do_load(32'h2007, 3'd1, 5'd5, 1'b1, 0);

        for (int i = 0; i < 24; i++) begin
            do_load(32'h1000 + 32'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                    5'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        reset_mid_flight();
        check("mem_addr_idle_zero", 64'(leak_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory bus width in bits (legal values 32, 64).
REQ-002 SHALL derive localparam BYTES = DATA_W/8 and OFF_W = log2(BYTES).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req_valid in 1 and req_ready out 1: request handshake.
REQ-006 SHALL have ports req_addr in 32 (byte address), req_type in 3 (load type), req_rd in 5 (destination register tag).
REQ-007 SHALL have ports mem_rd_en out 1 and mem_addr out 32: BYTES-aligned read strobe and address.
REQ-008 SHALL have port mem_rdata in DATA_W: read data, valid exactly one cycle after mem_rd_en.
REQ-009 SHALL have ports rsp_valid out 1 and rsp_ready in 1: response handshake.
REQ-010 SHALL have ports rsp_data out 32, rsp_rd out 5, rsp_exc out 1 (misaligned exception).

Function
REQ-011 SHALL decode req_type: 000 LW, 001 LB, 010 LH, 011 LBU, 100 LHU, 101 LWRR; 110 and 111 SHALL be treated as LW.
REQ-012 SHALL take byte offset off = req_addr[OFF_W-1:0] and access size 1 (LB/LBU), 2 (LH/LHU) or 4 (LW/LWRR); memory order is little-endian.
REQ-013 SHALL classify an access as spanning when off + size > BYTES; LWRR SHALL never span.
REQ-014 SHALL sign-extend LB/LH and zero-extend LBU/LHU to 32 bits.
REQ-015 SHALL make LWRR select the 32-bit lane containing req_addr and rotate it right by 8*req_addr[1:0].
REQ-016 SHALL implement FSM states IDLE, RD_LO, RD_HI, WAIT, RESP; req_ready = (state == IDLE).
REQ-017 SHALL latch addr, type and rd on accept (req_valid && req_ready) and move IDLE->RD_LO, or IDLE->RESP for an exception (REQ-026).
REQ-018 SHALL, in RD_LO, assert mem_rd_en with mem_addr = addr & ~(BYTES-1), then go to RD_HI if spanning, else WAIT.
REQ-019 SHALL, in RD_HI, assert mem_rd_en with mem_addr = aligned addr + BYTES, capture mem_rdata as the low beat, then go to WAIT.
REQ-020 SHALL, in WAIT, capture the final beat, merge {hi,lo} when spanning, extract/extend into the rsp_data register, then go to RESP.
REQ-021 SHALL hold rsp_valid = 1 in RESP with rsp_data/rsp_rd/rsp_exc stable, and return to IDLE on rsp_ready.
REQ-022 SHALL give latency accept->rsp_valid of 3 cycles non-spanning, 4 spanning, 1 exception; throughput is one load in flight.
REQ-023 SHALL keep mem_rd_en = 0 in every state except RD_LO and RD_HI; mem_addr SHALL be 0 when mem_rd_en = 0.
REQ-024 SHALL set mem_addr wrap-around to modulo 2^32 (0xFFFF_FFFC + 4 -> 0x0000_0000).

Reset
REQ-025 SHALL, on reset assertion in any state, go to IDLE immediately, drop any in-flight load, and drive rsp_valid=0, mem_rd_en=0, mem_addr=0, rsp_data=0, rsp_rd=0, rsp_exc=0; req_ready=1 after reset is released.

Configuration
REQ-026 With LDU_UNALIGNED_SPLIT_EN defined, spanning loads SHALL use the two-beat RD_LO->RD_HI path and rsp_exc SHALL always be 0.
REQ-027 Without LDU_UNALIGNED_SPLIT_EN, spanning loads SHALL issue no memory read, respond with rsp_exc=1 and rsp_data=0, and RD_HI SHALL be unreachable.

Structure
REQ-028 SHALL place the load-type encodings, the FSM state encoding and the size constants in shared package ldu_pkg.
REQ-029 SHALL place lane select, merge, extension and rotation in the combinational sub-module ldu_extract; load_align_unit holds the FSM and registers.

Verification
REQ-030 DATA_W=32, LB at 0x1003, word 0x80FF_1234 -> rsp_data 0xFFFF_FF80, rsp_valid at T+3, one mem read at 0x1000.
REQ-031 DATA_W=64, LHU at 0x2006, dword 0xBEEF_0000_0000_0000 -> rsp_data 0x0000_BEEF, mem_addr 0x2000.
REQ-032 DATA_W=32, LW at 0x1001, [0x1000]=0x4433_2211, [0x1004]=0x8877_6655 -> with macro: reads 0x1000 then 0x1004, rsp_data 0x5544_3322 at T+4; without macro: no mem_rd_en, rsp_exc=1, rsp_data=0 at T+1.
REQ-033 LWRR at 0x3002, word 0xAABB_CCDD -> rsp_data 0xCCDD_AABB.
REQ-034 rsp_ready held low 5 cycles in RESP -> rsp_data/rsp_rd stable, req_ready=0, no accept; rsp_ready=1 -> IDLE next cycle.
REQ-035 reset pulsed while in RD_HI -> IDLE with all outputs zero, no rsp_valid; the next LB request completes correctly.
